button_event_gen: RTL and testbench
===================================

// Module: button_event_gen
// PURPOSE
//  Input-side producer for the watch controller: turns NUM_BTN raw push-buttons into clean
//  levels and one-cycle events (press, short click, long hold, optional auto-repeat).
//  Replaces the ad-hoc edge/long-press counters in the top level; start/stop uses short_pulse,
//  reset uses long_pulse, and mode advance uses press_pulse. Instances are per-button and independent.
// PARAMETERS
//  NUM_BTN          4            number of buttons, all processed in parallel
//  DEBOUNCE_CYCLES  1_000_000    cycles of stable synced input needed to accept a change (10 ms @100 MHz)
//  LONG_CYCLES      250_000_000  cycles held, counted from the accepted press, to fire long_pulse (2.5 s)
//  REPEAT_CYCLES    25_000_000   auto-repeat period after the long hold (AUTO_REPEAT_EN only)
// PORTS
//  clk           in   1        system clock, all logic on the rising edge
//  rst_n         in   1        asynchronous active-low reset
//  btn_raw       in   NUM_BTN  raw asynchronous buttons, 1 = pressed
//  btn_level     out  NUM_BTN  debounced level
//  press_pulse   out  NUM_BTN  1-cycle pulse when a press is accepted
//  short_pulse   out  NUM_BTN  1-cycle pulse when a release is accepted before long_pulse fired
//  long_pulse    out  NUM_BTN  1-cycle pulse when the hold reaches LONG_CYCLES, once per press
//  repeat_pulse  out  NUM_BTN  1-cycle auto-repeat pulses; constant 0 without AUTO_REPEAT_EN
// BEHAVIOUR
//  - Reset (async assert, sync deassert through the clk domain): all outputs 0, FSMs in IDLE,
//    counters 0, synchronizer flops 0.
//  - Each btn_raw bit passes through a 2-flop synchronizer (s = 2nd flop) before any use.
//  - Per-button FSM states:
//    IDLE: leave when s=1; db_cnt starts at 1 -> PRESS_DB.
//    PRESS_DB: s=1 -> db_cnt++; s=0 -> IDLE with db_cnt=0 (a glitch restarts the filter).
//      When db_cnt reaches DEBOUNCE_CYCLES -> HELD; in that cycle btn_level<=1, press_pulse<=1, hold_cnt<=0.
//    HELD: hold_cnt++ each cycle. When hold_cnt reaches LONG_CYCLES: long_pulse<=1, long_done<=1, -> LONG.
//      s=0 -> REL_DB.
//    LONG: hold_cnt saturates; s=0 -> REL_DB.
//    REL_DB: s=0 -> db_cnt++; s=1 -> back to HELD or LONG per long_done, with db_cnt=0.
//      hold_cnt keeps counting in REL_DB, so long_pulse may fire here; the FSM then stays in REL_DB.
//      When db_cnt reaches DEBOUNCE_CYCLES -> IDLE; btn_level<=0; short_pulse<=1 iff !long_done; long_done<=0.
//  - Latency: btn_level, press_pulse, and short_pulse are registered. They change exactly
//    2+DEBOUNCE_CYCLES cycles after a clean input edge.
//  - At most one of press/short/long/repeat is asserted per button per cycle. Pulses never stretch.
//  - Buttons are fully independent; simultaneous presses produce simultaneous pulses.
//  - Button held through reset deassertion: treated as a fresh press after the full debounce.
//  - Counter widths are $clog2(max(param)+1). No wrap-around: all counters saturate.
//  - Reset mid-hold: no short or long pulse is emitted, on assertion or on release.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//    - While in LONG, repeat_pulse fires every REPEAT_CYCLES cycles.
//    - The first repeat comes REPEAT_CYCLES after long_pulse.
//    - rep_cnt clears on leaving LONG and freezes in REL_DB.
//    - Used by setup/alarm for fast hour/minute increment.
//  AUTO_REPEAT_EN undefined: repeat_pulse tied to 0; no rep_cnt logic is synthesized.
// TESTING  (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
//  1. Clean press at cycle 0, held for 10 cycles -> press_pulse and btn_level rise at cycle 6.
//     Release -> btn_level falls and short_pulse fires 6 cycles after release; no long_pulse.
//  2. Press, then 1-cycle low glitches every 3 cycles for 30 cycles -> no press_pulse, btn_level stays 0.
//     Then stable high -> press_pulse 6 cycles after the last glitch.
//  3. Hold for 40 cycles -> long_pulse exactly once, 20 cycles after press_pulse.
//     Release -> btn_level falls; no short_pulse.
//  4. btn_raw[0] and btn_raw[3] pressed in the same cycle -> press_pulse=4'b1001 in a single cycle.
//     Other bits stay 0.
//  5. rst_n=0 asserted mid-hold at hold_cnt=10 -> all outputs 0 immediately.
//     Release rst_n with the button still held -> new press_pulse after 6 cycles; long_pulse 20 cycles later.
//  6. AUTO_REPEAT_EN, hold for 40 cycles after press -> long_pulse at +20, repeat_pulse at +25,+30,+35,+40.
//     Without the macro, repeat_pulse stays 0.

Source files
------------

// File: rtl/button_event_gen.sv
// Per-button synchronizer, debounce FSM and press/short/long event pulses.
// Define AUTO_REPEAT_EN to add periodic repeat_pulse while a long hold continues.
module button_event_gen #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 250_000_000,
  parameter int unsigned REPEAT_CYCLES   = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] short_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    REL_DB
  } state_e;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    state_e              state_q;
    logic [DB_W-1:0]     db_cnt_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                long_done_q;
    logic                level_q;
    logic                press_q;
    logic                short_q;
    logic                long_q;
    logic                s;
    logic                db_hit;
    logic                long_hit;

    assign s        = sync2_q[i];
    assign db_hit   = (db_cnt_q >= DB_LAST);
    assign long_hit = !long_done_q && (hold_cnt_q >= HOLD_LAST);

`ifdef AUTO_REPEAT_EN
    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_q;

    // rep_cnt runs only while held in LONG, freezes across a release bounce, clears on full release.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_q <= '0;
        rep_q     <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (state_q == LONG && s) begin
          if (rep_cnt_q >= REP_LAST) begin
            rep_q     <= 1'b1;
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end else if (state_q == IDLE || state_q == PRESS_DB || state_q == HELD) begin
          rep_cnt_q <= '0;
        end
      end
    end

    assign repeat_pulse[i] = rep_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= IDLE;
        db_cnt_q    <= '0;
        hold_cnt_q  <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        short_q     <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        press_q <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        case (state_q)
          IDLE, PRESS_DB: begin
            if (s) begin
              if (db_hit) begin
                state_q    <= HELD;
                db_cnt_q   <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b1;
                press_q    <= 1'b1;
              end else begin
                state_q  <= PRESS_DB;
                db_cnt_q <= db_cnt_q + 1'b1;
              end
            end else begin
              state_q  <= IDLE;
              db_cnt_q <= '0;
            end
          end
          default: begin
            if (hold_cnt_q != HOLD_MAX) hold_cnt_q <= hold_cnt_q + 1'b1;
            if (!s) begin
              // Accepted release takes precedence over a long hold maturing in the same cycle.
              if (db_hit) begin
                state_q     <= IDLE;
                db_cnt_q    <= '0;
                hold_cnt_q  <= '0;
                level_q     <= 1'b0;
                short_q     <= !long_done_q;
                long_done_q <= 1'b0;
              end else begin
                state_q  <= REL_DB;
                db_cnt_q <= db_cnt_q + 1'b1;
                if (long_hit) begin
                  long_q      <= 1'b1;
                  long_done_q <= 1'b1;
                end
              end
            end else begin
              db_cnt_q <= '0;
              if (long_hit) begin
                long_q      <= 1'b1;
                long_done_q <= 1'b1;
                state_q     <= LONG;
              end else begin
                state_q <= long_done_q ? LONG : HELD;
              end
            end
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign press_pulse[i] = press_q;
    assign short_pulse[i] = short_q;
    assign long_pulse[i]  = long_q;
  end

`ifndef AUTO_REPEAT_EN
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with small debounce/long/repeat periods.
module tb_button_event_gen;

  localparam int unsigned NB = 4;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] short_pulse;
  logic [NB-1:0] long_pulse;
  logic [NB-1:0] repeat_pulse;

  int checks = 0;
  int errors = 0;
  int n_press, n_short, n_long, n_rep;

  always #5 clk = ~clk;

  button_event_gen #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_press += $countones(press_pulse);
    n_short += $countones(short_pulse);
    n_long  += $countones(long_pulse);
    n_rep   += $countones(repeat_pulse);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    n_press = 0;
    n_short = 0;
    n_long  = 0;
    n_rep   = 0;
  endtask

  initial begin
    clr();
    rst_n   = 1'b0;
    btn_raw = '0;
    ticks(3);
    check("rst_outs", {btn_level, press_pulse, short_pulse, long_pulse, repeat_pulse}, 20'h0);
    rst_n = 1'b1;
    ticks(3);

    // 1: clean short press
    clr();
    btn_raw = 4'b0001;
    ticks(5);
    check("t1_pre", {btn_level, press_pulse}, 8'h00);
    tick();
    check("t1_level", btn_level, 4'b0001);
    check("t1_press", press_pulse, 4'b0001);
    ticks(4);
    check("t1_press_once", n_press, 1);
    btn_raw = '0;
    ticks(5);
    check("t1_rel_pre", {btn_level, short_pulse}, 8'h10);
    tick();
    check("t1_rel_level", btn_level, 4'b0000);
    check("t1_short", short_pulse, 4'b0001);
    tick();
    check("t1_short_end", short_pulse, 4'b0000);
    check("t1_n_short", n_short, 1);
    check("t1_n_long", n_long, 0);

    // 2: glitchy press is rejected, then accepted once stable
    ticks(4);
    clr();
    for (int g = 0; g < 10; g++) begin
      btn_raw = 4'b0001;
      ticks(2);
      btn_raw = 4'b0000;
      tick();
    end
    check("t2_no_press", n_press, 0);
    check("t2_level", btn_level, 4'b0000);
    btn_raw = 4'b0001;
    ticks(5);
    check("t2_pre", press_pulse, 4'b0000);
    tick();
    check("t2_press", press_pulse, 4'b0001);
    check("t2_level_up", btn_level, 4'b0001);

    // 3/6: long hold, optional auto-repeat
    for (int k = 1; k <= 40; k++) begin
      tick();
      check("t3_long", long_pulse, (k == 20) ? 4'b0001 : 4'b0000);
      check("t3_rep", repeat_pulse,
            (REP_EN && k > 20 && (k - 20) % 5 == 0) ? 4'b0001 : 4'b0000);
    end
    check("t3_n_long", n_long, 1);
    check("t3_n_rep", n_rep, REP_EN ? 4 : 0);
    btn_raw = '0;
    ticks(5);
    check("t3_rel_pre", btn_level, 4'b0001);
    tick();
    check("t3_rel_level", btn_level, 4'b0000);
    check("t3_no_short", short_pulse, 4'b0000);
    ticks(2);
    check("t3_n_short", n_short, 0);

    // 4: simultaneous presses on buttons 0 and 3
    ticks(4);
    clr();
    btn_raw = 4'b1001;
    ticks(5);
    check("t4_pre", press_pulse, 4'b0000);
    tick();
    check("t4_press", press_pulse, 4'b1001);
    check("t4_level", btn_level, 4'b1001);
    tick();
    check("t4_press_end", press_pulse, 4'b0000);
    btn_raw = '0;
    ticks(6);
    check("t4_short", short_pulse, 4'b1001);
    check("t4_rel_level", btn_level, 4'b0000);

    // 5: reset mid-hold, button still held after release of reset
    ticks(4);
    clr();
    btn_raw = 4'b0001;
    ticks(6);
    check("t5_press", press_pulse, 4'b0001);
    ticks(10);
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", {btn_level, press_pulse, short_pulse, long_pulse, repeat_pulse}, 20'h0);
    ticks(2);
    rst_n = 1'b1;
    ticks(5);
    check("t5_pre", {btn_level, press_pulse}, 8'h00);
    tick();
    check("t5_repress", press_pulse, 4'b0001);
    ticks(19);
    check("t5_long_pre", long_pulse, 4'b0000);
    tick();
    check("t5_long", long_pulse, 4'b0001);
    btn_raw = '0;
    ticks(8);
    check("t5_n_short", n_short, 0);
    check("t5_n_long", n_long, 1);
    check("t5_level", btn_level, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
